// File: rtl/exe_stage_if.sv
// ----------------------------------------------------------------------------
// exe_stage_if
// Groups the execute-stage handshake and data buses:
//   decode -> execute : ds_to_es_valid, ds_* instruction payload
//   execute -> decode : es_allowin, es_rf_we/es_rf_waddr (hazard detection)
//   memory  -> execute: ms_allowin
//   execute -> memory : es_to_ms_valid, es_* payload
//   execute -> SRAM   : data_sram_en/we/addr/wdata
// Modports:
//   slave  - the execute stage itself
//   master - the surrounding pipeline (or a testbench) driving it
// ----------------------------------------------------------------------------
interface exe_stage_if;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic        ms_allowin;
    logic [31:0] ds_pc;
    logic [3:0]  ds_alu_op;
    logic [31:0] ds_alu_src1;
    logic [31:0] ds_alu_src2;
    logic        ds_div_en;
    logic        ds_div_signed;
    logic        ds_div_rem;
    logic        ds_mem_we;
    logic        ds_res_from_mem;
    logic [1:0]  ds_mem_size;
    logic [31:0] ds_store_data;
    logic        ds_rf_we;
    logic [4:0]  ds_rf_waddr;

    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic        es_res_from_mem;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;

    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport slave (
        input  ds_to_es_valid, ms_allowin, ds_pc, ds_alu_op, ds_alu_src1,
               ds_alu_src2, ds_div_en, ds_div_signed, ds_div_rem, ds_mem_we,
               ds_res_from_mem, ds_mem_size, ds_store_data, ds_rf_we,
               ds_rf_waddr,
        output es_allowin, es_to_ms_valid, es_pc, es_alu_result,
               es_res_from_mem, es_rf_we, es_rf_waddr, data_sram_en,
               data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport master (
        output ds_to_es_valid, ms_allowin, ds_pc, ds_alu_op, ds_alu_src1,
               ds_alu_src2, ds_div_en, ds_div_signed, ds_div_rem, ds_mem_we,
               ds_res_from_mem, ds_mem_size, ds_store_data, ds_rf_we,
               ds_rf_waddr,
        input  es_allowin, es_to_ms_valid, es_pc, es_alu_result,
               es_res_from_mem, es_rf_we, es_rf_waddr, data_sram_en,
               data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/exe_stage.sv
// ----------------------------------------------------------------------------
// exe_stage
// Execute stage of a 5-stage pipeline: 13-op ALU, 32-cycle restoring
// divider (signed/unsigned, quotient/remainder) and data SRAM request
// generation for loads and stores.
// Ports:
//   clk    - pipeline clock, rising edge
//   resetn - synchronous active-low reset
//   bus    - exe_stage_if.slave: decode/memory handshakes, payloads, SRAM
// ----------------------------------------------------------------------------
module exe_stage (
    input  logic        clk,
    input  logic        resetn,
    exe_stage_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_t;

    logic        es_valid_reg;
    logic [31:0] es_pc_reg;
    logic [3:0]  es_alu_op_reg;
    logic [31:0] es_src1_reg;
    logic [31:0] es_src2_reg;
    logic        es_div_en_reg;
    logic        es_div_signed_reg;
    logic        es_div_rem_reg;
    logic        es_mem_we_reg;
    logic        es_res_from_mem_reg;
    logic [1:0]  es_mem_size_reg;
    logic [31:0] es_store_data_reg;
    logic        es_rf_we_reg;
    logic [4:0]  es_rf_waddr_reg;

    div_state_t  div_state_reg;
    logic [5:0]  div_cnt_reg;
    logic [31:0] div_quo_reg;   // dividend magnitude shifts out, quotient shifts in
    logic [31:0] div_rem_reg;   // partial remainder
    logic [31:0] div_dvs_reg;   // divisor magnitude

    logic        es_ready_go;
    logic        es_allowin;
    logic        es_to_ms_valid;
    logic        ds_accept;
    logic        div_start;
    logic        handoff;

    assign es_ready_go    = !es_valid_reg || !es_div_en_reg || (div_state_reg == DONE);
    assign es_allowin     = !es_valid_reg || (es_ready_go && bus.ms_allowin);
    assign es_to_ms_valid = es_valid_reg && es_ready_go;
    assign ds_accept      = bus.ds_to_es_valid && es_allowin;
    assign div_start      = ds_accept && bus.ds_div_en;
    assign handoff        = es_to_ms_valid && bus.ms_allowin;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Pipeline valid and payload registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            es_valid_reg        <= 1'b0;
            es_pc_reg           <= '0;
            es_alu_op_reg       <= '0;
            es_src1_reg         <= '0;
            es_src2_reg         <= '0;
            es_div_en_reg       <= 1'b0;
            es_div_signed_reg   <= 1'b0;
            es_div_rem_reg      <= 1'b0;
            es_mem_we_reg       <= 1'b0;
            es_res_from_mem_reg <= 1'b0;
            es_mem_size_reg     <= '0;
            es_store_data_reg   <= '0;
            es_rf_we_reg        <= 1'b0;
            es_rf_waddr_reg     <= '0;
        end else begin
            if (es_allowin) begin
                es_valid_reg <= bus.ds_to_es_valid;
            end
            if (ds_accept) begin
                es_pc_reg           <= bus.ds_pc;
                es_alu_op_reg       <= bus.ds_alu_op;
                es_src1_reg         <= bus.ds_alu_src1;
                es_src2_reg         <= bus.ds_alu_src2;
                es_div_en_reg       <= bus.ds_div_en;
                es_div_signed_reg   <= bus.ds_div_signed;
                es_div_rem_reg      <= bus.ds_div_rem;
                es_mem_we_reg       <= bus.ds_mem_we;
                es_res_from_mem_reg <= bus.ds_res_from_mem;
                es_mem_size_reg     <= bus.ds_mem_size;
                es_store_data_reg   <= bus.ds_store_data;
                es_rf_we_reg        <= bus.ds_rf_we;
                es_rf_waddr_reg     <= bus.ds_rf_waddr;
            end
        end
    end

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor; a borrow (bit 32) means the trial failed.
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    assign div_shift = {div_rem_reg, div_quo_reg[31]};
    assign div_diff  = div_shift - {1'b0, div_dvs_reg};

    // Divider FSM. The operands are taken straight from the decode bus on
    // the accept edge so iteration starts in the very next cycle. A start
    // can only arrive in IDLE or DONE, since BUSY holds es_allowin low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_state_reg <= IDLE;
            div_cnt_reg   <= '0;
            div_quo_reg   <= '0;
            div_rem_reg   <= '0;
            div_dvs_reg   <= '0;
        end else if (div_start) begin
            div_state_reg <= BUSY;
            div_cnt_reg   <= '0;
            div_rem_reg   <= '0;
            div_quo_reg   <= magnitude(bus.ds_alu_src1, bus.ds_div_signed);
            div_dvs_reg   <= magnitude(bus.ds_alu_src2, bus.ds_div_signed);
        end else begin
            case (div_state_reg)
                BUSY: begin
                    div_rem_reg <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
                    div_quo_reg <= {div_quo_reg[30:0], !div_diff[32]};
                    div_cnt_reg <= div_cnt_reg + 6'd1;
                    if (div_cnt_reg == 6'd31) begin
                        div_state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (handoff) begin
                        div_state_reg <= IDLE;
                    end
                end
                default: div_state_reg <= IDLE;
            endcase
        end
    end

    // Sign fix-up; divide by zero is forced so signed and unsigned agree.
    logic        quo_neg;
    logic        rem_neg;
    logic [31:0] div_result;
    assign quo_neg = es_div_signed_reg && (es_src1_reg[31] ^ es_src2_reg[31]);
    assign rem_neg = es_div_signed_reg && es_src1_reg[31];
    assign div_result = (es_src2_reg == 32'd0) ? (es_div_rem_reg ? es_src1_reg : 32'hFFFF_FFFF) :
                        es_div_rem_reg ? (rem_neg ? 32'd0 - div_rem_reg : div_rem_reg) :
                                         (quo_neg ? 32'd0 - div_quo_reg : div_quo_reg);

    // ALU
    logic [31:0] alu_result;
    logic [31:0] mul_low;
    logic [31:0] sra_result;
    assign mul_low    = es_src1_reg * es_src2_reg;
    assign sra_result = $unsigned($signed(es_src1_reg) >>> es_src2_reg[4:0]);

    always_comb begin
        alu_result = '0;
        case (es_alu_op_reg)
            4'd0:  alu_result = es_src1_reg + es_src2_reg;
            4'd1:  alu_result = es_src1_reg - es_src2_reg;
            4'd2:  alu_result = {31'd0, $signed(es_src1_reg) < $signed(es_src2_reg)};
            4'd3:  alu_result = {31'd0, es_src1_reg < es_src2_reg};
            4'd4:  alu_result = es_src1_reg & es_src2_reg;
            4'd5:  alu_result = es_src1_reg | es_src2_reg;
            4'd6:  alu_result = ~(es_src1_reg | es_src2_reg);
            4'd7:  alu_result = es_src1_reg ^ es_src2_reg;
            4'd8:  alu_result = es_src1_reg << es_src2_reg[4:0];
            4'd9:  alu_result = es_src1_reg >> es_src2_reg[4:0];
            4'd10: alu_result = sra_result;
            4'd11: alu_result = es_src2_reg;
            4'd12: alu_result = mul_low;
            default: alu_result = '0;
        endcase
    end

    logic [31:0] es_alu_result;
    assign es_alu_result = es_div_en_reg ? div_result : alu_result;

    // SRAM request: per-lane byte enable and data steering. Misaligned
    // half/word accesses simply ignore the low address bits.
    logic        sram_en;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_we[gi] = (es_mem_size_reg == 2'd0) ? (es_alu_result[1:0] == LANE) :
                                 (es_mem_size_reg == 2'd1) ? (es_alu_result[1] == LANE[1]) :
                                                             1'b1;
            assign lane_wdata[8*gi +: 8] =
                (es_mem_size_reg == 2'd0) ? es_store_data_reg[7:0] :
                (es_mem_size_reg == 2'd1) ? (LANE[0] ? es_store_data_reg[15:8] : es_store_data_reg[7:0]) :
                                            es_store_data_reg[8*gi +: 8];
        end
    endgenerate

    assign sram_en = handoff && (es_mem_we_reg || es_res_from_mem_reg);

    assign bus.es_allowin      = es_allowin;
    assign bus.es_to_ms_valid  = es_to_ms_valid;
    assign bus.es_pc           = es_pc_reg;
    assign bus.es_alu_result   = es_alu_result;
    assign bus.es_res_from_mem = es_res_from_mem_reg;
    assign bus.es_rf_we        = es_valid_reg && es_rf_we_reg;
    assign bus.es_rf_waddr     = es_rf_waddr_reg;
    assign bus.data_sram_en    = sram_en;
    assign bus.data_sram_we    = (sram_en && es_mem_we_reg) ? lane_we : 4'b0000;
    assign bus.data_sram_addr  = es_alu_result;
    assign bus.data_sram_wdata = lane_wdata;
endmodule

// File: tb/tb_exe_stage.sv
// ----------------------------------------------------------------------------
// tb_exe_stage
// Self-checking bench for exe_stage: randomized ALU/store/divide stimulus
// compared against arithmetic reference functions, plus directed handshake,
// stall, back-to-back divide and reset-abort scenarios.
// ----------------------------------------------------------------------------
module tb_exe_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    exe_stage_if bus();
    exe_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        rem;
    } div_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ds();
        bus.ds_to_es_valid  = 1'b0;
        bus.ds_pc           = '0;
        bus.ds_alu_op       = '0;
        bus.ds_alu_src1     = '0;
        bus.ds_alu_src2     = '0;
        bus.ds_div_en       = 1'b0;
        bus.ds_div_signed   = 1'b0;
        bus.ds_div_rem      = 1'b0;
        bus.ds_mem_we       = 1'b0;
        bus.ds_res_from_mem = 1'b0;
        bus.ds_mem_size     = '0;
        bus.ds_store_data   = '0;
        bus.ds_rf_we        = 1'b0;
        bus.ds_rf_waddr     = '0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] alu_model(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int unsigned sh;
        logic [31:0] r;
        sa = a;
        sb = b;
        sh = b % 32;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = (sa < sb) ? 32'd1 : 32'd0;
            3: r = (a < b) ? 32'd1 : 32'd0;
            4: r = a & b;
            5: r = a | b;
            6: r = ~(a | b);
            7: r = a ^ b;
            8: r = a << sh;
            9: r = a >> sh;
            10: r = sa >>> sh;
            11: r = b;
            12: r = a * b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn, input logic rem);
        logic neg_a;
        logic neg_b;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        neg_a = sgn && a[31];
        neg_b = sgn && b[31];
        ma = neg_a ? -a : a;
        mb = neg_b ? -b : b;
        q = ma / mb;
        r = ma % mb;
        if (neg_a ^ neg_b) q = -q;
        if (neg_a) r = -r;
        return rem ? r : q;
    endfunction

    task automatic test_reset();
        clear_ds();
        bus.ms_allowin = 1'b1;
        resetn = 1'b0;
        bus.ds_to_es_valid = 1'b1;
        bus.ds_pc = 32'h1234;
        bus.ds_rf_we = 1'b1;
        bus.ds_mem_we = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({bus.es_to_ms_valid, bus.es_allowin, bus.data_sram_en, bus.data_sram_we, bus.es_rf_we} !== 8'b0100_0000)
            $display("FAIL reset_ctrl: got v=%b allowin=%b en=%b we=%b rfwe=%b required 0 1 0 0000 0",
                     bus.es_to_ms_valid, bus.es_allowin, bus.data_sram_en, bus.data_sram_we, bus.es_rf_we);
        else pass_cnt++;
        total_cnt++;
        if ({bus.es_pc, bus.es_alu_result, bus.es_rf_waddr, bus.es_res_from_mem} !== 70'd0)
            $display("FAIL reset_payload: got pc=%h res=%h waddr=%h rfm=%b required all zero",
                     bus.es_pc, bus.es_alu_result, bus.es_rf_waddr, bus.es_res_from_mem);
        else pass_cnt++;
        clear_ds();
        resetn = 1'b1;
        tick();
    endtask

    // Streams one ALU instruction per cycle; each cycle checks the one
    // accepted on the previous edge.
    task automatic test_alu_back_to_back(input int n);
        logic        prev_valid = 1'b0;
        logic [31:0] prev_res = '0;
        logic [31:0] prev_pc = '0;
        logic        prev_rfwe = 1'b0;
        logic [4:0]  prev_waddr = '0;
        int unsigned op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i <= n; i++) begin
            clear_ds();
            bus.ms_allowin = 1'b1;
            if (i < n) begin
                op = (i == 0) ? 0 : $urandom_range(0, 15);
                a = (i == 0) ? 32'h7FFF_FFFF : pick();
                b = (i == 0) ? 32'h1 : pick();
                bus.ds_to_es_valid = 1'b1;
                bus.ds_pc = $urandom;
                bus.ds_alu_op = op[3:0];
                bus.ds_alu_src1 = a;
                bus.ds_alu_src2 = b;
                bus.ds_rf_we = 1'($urandom_range(0, 1));
                bus.ds_rf_waddr = 5'($urandom_range(0, 31));
            end
            #1;
            if (prev_valid) begin
                total_cnt++;
                if ({bus.es_to_ms_valid, bus.es_alu_result, bus.es_pc, bus.data_sram_en, bus.es_rf_we, bus.es_rf_waddr}
                    !== {1'b1, prev_res, prev_pc, 1'b0, prev_rfwe, prev_waddr})
                    $display("FAIL alu[%0d]: got v=%b res=%h pc=%h en=%b rfwe=%b wa=%0d required v=1 res=%h pc=%h en=0 rfwe=%b wa=%0d",
                             i - 1, bus.es_to_ms_valid, bus.es_alu_result, bus.es_pc, bus.data_sram_en,
                             bus.es_rf_we, bus.es_rf_waddr, prev_res, prev_pc, prev_rfwe, prev_waddr);
                else pass_cnt++;
            end
            total_cnt++;
            if (bus.es_allowin !== 1'b1)
                $display("FAIL alu_allowin[%0d]: got %b required 1", i, bus.es_allowin);
            else pass_cnt++;
            if (i < n) begin
                prev_valid = 1'b1;
                prev_res = alu_model(op, a, b);
                prev_pc = bus.ds_pc;
                prev_rfwe = bus.ds_rf_we;
                prev_waddr = bus.ds_rf_waddr;
            end
            tick();
        end
        total_cnt++;
        if ({bus.es_to_ms_valid, bus.es_rf_we} !== 2'b00)
            $display("FAIL alu_drain: got v=%b rfwe=%b required 0 0", bus.es_to_ms_valid, bus.es_rf_we);
        else pass_cnt++;
    endtask

    task automatic test_store(input int n);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        for (int i = 0; i < n; i++) begin
            clear_ds();
            bus.ms_allowin = 1'b1;
            if (i == 0) begin
                a = 32'h100; b = 32'h3; d = 32'hA5; sz = 2'd0;
            end else begin
                a = $urandom; b = 32'($urandom_range(0, 15)); d = $urandom; sz = 2'($urandom_range(0, 2));
            end
            addr = a + b;
            case (sz)
                2'd0: begin exp_we = 4'b0001 << addr[1:0]; exp_wd = {4{d[7:0]}}; end
                2'd1: begin exp_we = addr[1] ? 4'b1100 : 4'b0011; exp_wd = {2{d[15:0]}}; end
                default: begin exp_we = 4'b1111; exp_wd = d; end
            endcase
            bus.ds_to_es_valid = 1'b1;
            bus.ds_alu_op = 4'd0;
            bus.ds_alu_src1 = a;
            bus.ds_alu_src2 = b;
            bus.ds_mem_we = 1'b1;
            bus.ds_mem_size = sz;
            bus.ds_store_data = d;
            tick();
            bus.ds_to_es_valid = 1'b0;
            #1;
            total_cnt++;
            if ({bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.data_sram_wdata} !== {1'b1, exp_we, addr, exp_wd})
                $display("FAIL store[%0d] size=%0d: got en=%b we=%b addr=%h wdata=%h required en=1 we=%b addr=%h wdata=%h",
                         i, sz, bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.data_sram_wdata,
                         exp_we, addr, exp_wd);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({bus.data_sram_en, bus.data_sram_we} !== 5'b0)
                $display("FAIL store_after[%0d]: got en=%b we=%b required 0 0000", i, bus.data_sram_en, bus.data_sram_we);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_stall();
        int pulses = 0;
        clear_ds();
        bus.ms_allowin = 1'b1;
        bus.ds_to_es_valid = 1'b1;
        bus.ds_pc = 32'h400;
        bus.ds_alu_src1 = 32'h2000;
        bus.ds_alu_src2 = 32'h14;
        bus.ds_res_from_mem = 1'b1;
        bus.ds_mem_size = 2'd2;
        bus.ds_rf_we = 1'b1;
        bus.ds_rf_waddr = 5'd7;
        tick();
        // A different instruction waits in decode while memory stalls.
        bus.ds_pc = 32'h999;
        bus.ds_alu_src1 = 32'h5555;
        bus.ds_rf_waddr = 5'd9;
        bus.ms_allowin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.data_sram_en === 1'b1) pulses++;
            total_cnt++;
            if ({bus.data_sram_en, bus.es_to_ms_valid, bus.es_allowin, bus.es_pc, bus.es_alu_result, bus.es_rf_waddr}
                !== {1'b0, 1'b1, 1'b0, 32'h400, 32'h2014, 5'd7})
                $display("FAIL load_stall[%0d]: got en=%b v=%b allowin=%b pc=%h res=%h wa=%0d required 0 1 0 400 2014 7",
                         c, bus.data_sram_en, bus.es_to_ms_valid, bus.es_allowin, bus.es_pc, bus.es_alu_result, bus.es_rf_waddr);
            else pass_cnt++;
            tick();
        end
        bus.ds_to_es_valid = 1'b0;
        bus.ms_allowin = 1'b1;
        #1;
        if (bus.data_sram_en === 1'b1) pulses++;
        total_cnt++;
        if ({bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.es_res_from_mem} !== {1'b1, 4'b0000, 32'h2014, 1'b1})
            $display("FAIL load_release: got en=%b we=%b addr=%h rfm=%b required 1 0000 2014 1",
                     bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.es_res_from_mem);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.data_sram_en === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses != 1)
            $display("FAIL load_pulses: got %0d enable pulses required 1", pulses);
        else pass_cnt++;
    endtask

    task automatic drive_div(input div_vec_t v);
        clear_ds();
        bus.ms_allowin = 1'b1;
        bus.ds_to_es_valid = 1'b1;
        bus.ds_div_en = 1'b1;
        bus.ds_div_signed = v.sgn;
        bus.ds_div_rem = v.rem;
        bus.ds_alu_src1 = v.a;
        bus.ds_alu_src2 = v.b;
        bus.ds_rf_we = 1'b1;
        bus.ds_rf_waddr = 5'd3;
    endtask

    // Called right after the accept edge; returns with the result on the bus.
    task automatic wait_div(input string name, input div_vec_t v);
        int lat = 0;
        logic allowin_bad = 1'b0;
        logic [31:0] exp;
        exp = div_model(v.a, v.b, v.sgn, v.rem);
        #1;
        while (bus.es_to_ms_valid !== 1'b1 && lat < 100) begin
            if (bus.es_allowin !== 1'b0) allowin_bad = 1'b1;
            tick();
            #1;
            lat++;
        end
        total_cnt++;
        if (lat != 32 || allowin_bad)
            $display("FAIL %s_latency: got %0d stall cycles (allowin leak=%b) required 32", name, lat, allowin_bad);
        else pass_cnt++;
        total_cnt++;
        if ({bus.es_alu_result, bus.data_sram_en} !== {exp, 1'b0})
            $display("FAIL %s_result a=%h b=%h s=%b r=%b: got %h en=%b required %h en=0",
                     name, v.a, v.b, v.sgn, v.rem, bus.es_alu_result, bus.data_sram_en, exp);
        else pass_cnt++;
    endtask

    task automatic test_div(input int n_rand);
        div_vec_t vecs[$];
        div_vec_t v;
        vecs.push_back('{32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0});
        vecs.push_back('{32'hFFFF_FFF9, 32'h2, 1'b1, 1'b1});
        vecs.push_back('{32'h5, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{32'h5, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1});
        vecs.push_back('{32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0});
        for (int i = 0; i < n_rand; i++) begin
            v.a = pick();
            v.b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) - 32'd150 : pick();
            v.sgn = 1'($urandom_range(0, 1));
            v.rem = 1'($urandom_range(0, 1));
            vecs.push_back(v);
        end
        foreach (vecs[i]) begin
            drive_div(vecs[i]);
            tick();
            bus.ds_to_es_valid = 1'b0;
            wait_div($sformatf("div%0d", i), vecs[i]);
            tick();
        end
    endtask

    task automatic test_back_to_back_div();
        div_vec_t v1;
        div_vec_t v2;
        v1 = '{32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0};
        v2 = '{32'd100, 32'd7, 1'b0, 1'b1};
        drive_div(v1);
        tick();
        bus.ds_to_es_valid = 1'b0;
        wait_div("b2b_first", v1);
        drive_div(v2);
        #1;
        total_cnt++;
        if (bus.es_allowin !== 1'b1)
            $display("FAIL b2b_allowin: got %b required 1", bus.es_allowin);
        else pass_cnt++;
        tick();
        bus.ds_to_es_valid = 1'b0;
        wait_div("b2b_second", v2);
        tick();
    endtask

    task automatic test_reset_mid_div();
        div_vec_t v;
        logic stale = 1'b0;
        v = '{32'd1000, 32'd3, 1'b0, 1'b0};
        drive_div(v);
        tick();
        bus.ds_to_es_valid = 1'b0;
        repeat (10) tick();
        resetn = 1'b0;
        tick();
        total_cnt++;
        if ({bus.es_to_ms_valid, bus.es_allowin, bus.es_rf_we} !== 3'b010)
            $display("FAIL reset_abort: got v=%b allowin=%b rfwe=%b required 0 1 0",
                     bus.es_to_ms_valid, bus.es_allowin, bus.es_rf_we);
        else pass_cnt++;
        resetn = 1'b1;
        clear_ds();
        bus.ds_to_es_valid = 1'b1;
        bus.ds_alu_src1 = 32'd5;
        bus.ds_alu_src2 = 32'd6;
        tick();
        bus.ds_to_es_valid = 1'b0;
        #1;
        total_cnt++;
        if ({bus.es_to_ms_valid, bus.es_alu_result} !== {1'b1, 32'd11})
            $display("FAIL post_reset_add: got v=%b res=%h required v=1 res=0000000b",
                     bus.es_to_ms_valid, bus.es_alu_result);
        else pass_cnt++;
        repeat (40) begin
            tick();
            if (bus.es_to_ms_valid !== 1'b0) stale = 1'b1;
        end
        total_cnt++;
        if (stale !== 1'b0)
            $display("FAIL post_reset_stale: got stale valid=%b required 0", stale);
        else pass_cnt++;
    endtask

    initial begin
        clear_ds();
        bus.ms_allowin = 1'b1;
        test_reset();
        test_alu_back_to_back(40);
        test_store(12);
        test_load_stall();
        test_div(8);
        test_back_to_back_div();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
